// File: rtl/fetch_queue_ctrl.sv
// Dual-issue fetch sequencer: PC pair to ROM, circular queue, decode issue.
// Define FETCH_PERF_EN to add saturating fetch/stall/redirect counters.
module fetch_queue_ctrl #(
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [31:0]                  rom_pc,
    output logic [31:0]                  rom_pc_4,
    input  logic [31:0]                  rom_inst1,
    input  logic [31:0]                  rom_inst2,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    input  logic [1:0]                   issue_take,
    output logic                         issue_valid0,
    output logic [31:0]                  issue_inst0,
    output logic [31:0]                  issue_pc0,
    output logic                         issue_valid1,
    output logic [31:0]                  issue_inst1,
    output logic [31:0]                  issue_pc1,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                  perf_fetch_cnt,
    output logic [31:0]                  perf_stall_cnt,
    output logic [31:0]                  perf_redirect_cnt
`endif
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FREE_MAX = CW'(QUEUE_DEPTH - 2);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   fetch_pc;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_p1;
    logic [AW-1:0] tail_p1;
    logic [CW-1:0] count;
    logic [CW-1:0] count_pop;
    logic [CW-1:0] count_next;
    logic [1:0]    take_c;
    logic [1:0]    pop_n;
    logic          fetch_en;

    logic [31:0] inst_q [QUEUE_DEPTH];
    logic [31:0] pc_q   [QUEUE_DEPTH];

    assign rom_pc   = fetch_pc;
    assign rom_pc_4 = fetch_pc + 32'd4;

    assign head_p1 = head + AW'(1);
    assign tail_p1 = tail + AW'(1);

    assign issue_valid0 = (count >= CW'(1));
    assign issue_valid1 = (count >= CW'(2));
    assign issue_inst0  = inst_q[head];
    assign issue_pc0    = pc_q[head];
    assign issue_inst1  = inst_q[head_p1];
    assign issue_pc1    = pc_q[head_p1];
    assign queue_count  = count;

    // Decode has two slots; pops never exceed what is actually queued.
    always_comb begin
        take_c = (issue_take > 2'd2) ? 2'd2 : issue_take;
        pop_n  = take_c;
        if (CW'(take_c) > count) begin
            pop_n = count[1:0];
        end
        count_pop  = count - CW'(pop_n);
        fetch_en   = (state == RUN) && !redirect_valid
                     && (count <= FREE_MAX);
        count_next = count_pop + (fetch_en ? CW'(2) : CW'(0));
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (!redirect_valid && (count > FREE_MAX)) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                if (count_pop <= FREE_MAX) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
        if (redirect_valid) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            state    <= RUN;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~32'd3;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            state    <= RUN;
        end else begin
            head  <= head + AW'(pop_n);
            count <= count_next;
            state <= state_next;
            if (fetch_en) begin
                tail     <= tail + AW'(2);
                fetch_pc <= fetch_pc + 32'd8;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fetch_en) begin
            inst_q[tail]    <= rom_inst1;
            pc_q[tail]      <= fetch_pc;
            inst_q[tail_p1] <= rom_inst2;
            pc_q[tail_p1]   <= fetch_pc + 32'd4;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt    <= '0;
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (fetch_en && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if ((state == STALL) && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redirect_valid && (perf_redirect_cnt != '1)) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Bench for fetch_queue_ctrl: directed plan steps, then random traffic
// checked against a queue-based reference model.
module tb_fetch_queue_ctrl;

    localparam int DEPTH = 8;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] rom_pc;
    logic [31:0] rom_pc_4;
    logic [31:0] rom_inst1;
    logic [31:0] rom_inst2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  issue_take;
    logic        issue_valid0;
    logic [31:0] issue_inst0;
    logic [31:0] issue_pc0;
    logic        issue_valid1;
    logic [31:0] issue_inst1;
    logic [31:0] issue_pc1;
    logic [3:0]  queue_count;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    fetch_queue_ctrl #(
        .QUEUE_DEPTH(DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_pc        (rom_pc),
        .rom_pc_4      (rom_pc_4),
        .rom_inst1     (rom_inst1),
        .rom_inst2     (rom_inst2),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .issue_take    (issue_take),
        .issue_valid0  (issue_valid0),
        .issue_inst0   (issue_inst0),
        .issue_pc0     (issue_pc0),
        .issue_valid1  (issue_valid1),
        .issue_inst1   (issue_inst1),
        .issue_pc1     (issue_pc1),
        .queue_count   (queue_count)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign rom_inst1 = rom_word(rom_pc);
    assign rom_inst2 = rom_word(rom_pc_4);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_stall;
    bit          m_init;
    int unsigned m_fetch;
    int unsigned m_stalls;
    int unsigned m_redir;

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit rv,
                         input logic [31:0] rp, input logic [1:0] tk);
        int   n;
        bit   can;
        ent_t e;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        issue_take     = tk;
        #1;
        if (m_init) begin
            chk("rom_pc", rom_pc, m_pc);
            chk("rom_pc_4", rom_pc_4, m_pc + 32'd4);
            chk("count", 32'(queue_count), mq.size());
            chk("valid0", 32'(issue_valid0), 32'(mq.size() >= 1));
            chk("valid1", 32'(issue_valid1), 32'(mq.size() >= 2));
            if (mq.size() >= 1) begin
                chk("pc0", issue_pc0, mq[0].pc);
                chk("inst0", issue_inst0, mq[0].inst);
            end
            if (mq.size() >= 2) begin
                chk("pc1", issue_pc1, mq[1].pc);
                chk("inst1", issue_inst1, mq[1].inst);
            end
`ifdef FETCH_PERF_EN
            chk("perf_fetch", perf_fetch_cnt, m_fetch);
            chk("perf_stall", perf_stall_cnt, m_stalls);
            chk("perf_redir", perf_redirect_cnt, m_redir);
`endif
        end
        if (r) begin
            mq.delete();
            m_pc     = RST_PC;
            m_stall  = 0;
            m_init   = 1;
            m_fetch  = 0;
            m_stalls = 0;
            m_redir  = 0;
        end else begin
            if (m_stall) m_stalls++;
            if (rv) begin
                m_redir++;
                mq.delete();
                m_pc    = {rp[31:2], 2'b00};
                m_stall = 0;
            end else begin
                can = !m_stall && (DEPTH - mq.size() >= 2);
                n = (int'(tk) < mq.size()) ? int'(tk) : mq.size();
                repeat (n) void'(mq.pop_front());
                if (can) begin
                    e.pc = m_pc;
                    e.inst = rom_word(m_pc);
                    mq.push_back(e);
                    e.pc = m_pc + 32'd4;
                    e.inst = rom_word(m_pc + 32'd4);
                    mq.push_back(e);
                    m_pc = m_pc + 32'd8;
                    m_fetch++;
                end
                if (m_stall) m_stall = (DEPTH - mq.size() < 2);
                else m_stall = !can;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] tk;
        bit         r;
        bit         rv;
        bit         mode;
        checks = 0;
        errors = 0;
        m_init = 0;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        issue_take = '0;

        // reset and first fetch
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("t1_rom_pc", rom_pc, 32'h0);
        chk("t1_valid0_rst", 32'(issue_valid0), 32'h0);
        cycle(0, 0, 0, 0);
        chk("t1_valid0", 32'(issue_valid0), 32'h1);
        chk("t1_pc0", issue_pc0, 32'h0);
        chk("t1_inst0", issue_inst0, 32'h1000_0000);
        chk("t1_valid1", 32'(issue_valid1), 32'h1);
        chk("t1_pc1", issue_pc1, 32'h4);
        chk("t1_inst1", issue_inst1, 32'h1000_0001);
        chk("t1_count", 32'(queue_count), 32'd2);

        // fill to full and stall
        repeat (5) cycle(0, 0, 0, 0);
        chk("t2_count", 32'(queue_count), 32'd8);
        chk("t2_rom_pc", rom_pc, 32'h20);
        chk("t2_pc0", issue_pc0, 32'h0);
        cycle(0, 0, 0, 2);
        chk("t2_pop_count", 32'(queue_count), 32'd6);
        chk("t2_pop_pc0", issue_pc0, 32'h8);
        cycle(0, 0, 0, 0);
        chk("t2_push_count", 32'(queue_count), 32'd8);
        chk("t2_push_rom_pc", rom_pc, 32'h28);

        // steady dual issue
        cycle(1, 0, 0, 0);
        repeat (12) cycle(0, 0, 0, 2);
        chk("t3_count", 32'(queue_count), 32'd2);
        chk("t3_pc0", issue_pc0, 32'h58);

        // redirect with pop request
        cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        chk("t4_count6", 32'(queue_count), 32'd6);
        cycle(0, 1, 32'h103, 2);
        chk("t4_count", 32'(queue_count), 32'd0);
        chk("t4_valid0", 32'(issue_valid0), 32'h0);
        chk("t4_rom_pc", rom_pc, 32'h100);
        cycle(0, 0, 0, 2);
        chk("t4_pc0", issue_pc0, 32'h100);
        chk("t4_pc1", issue_pc1, 32'h104);

        // PC wrap at top of address space
        cycle(0, 1, 32'hFFFF_FFF9, 0);
        chk("wrap_rom_pc", rom_pc, 32'hFFFF_FFF8);
        chk("wrap_rom_pc_4", rom_pc_4, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        chk("wrap_next_pc", rom_pc, 32'h0);
        chk("wrap_pc1", issue_pc1, 32'hFFFF_FFFC);
        chk("wrap_inst1", issue_inst1, 32'h4FFF_FFFF);

        // reset beats redirect while full
        repeat (4) cycle(0, 0, 0, 0);
        chk("t6_full", 32'(queue_count), 32'd8);
        cycle(1, 1, 32'h500, 2);
        chk("t6_count", 32'(queue_count), 32'd0);
        chk("t6_rom_pc", rom_pc, RST_PC);
        chk("t6_valid0", 32'(issue_valid0), 32'h0);
`ifdef FETCH_PERF_EN
        chk("t6_perf_fetch", perf_fetch_cnt, 32'h0);
        chk("t6_perf_stall", perf_stall_cnt, 32'h0);
        chk("t6_perf_redir", perf_redirect_cnt, 32'h0);
`endif

        // random traffic
        mode = 0;
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) mode = ~mode;
            r  = ($urandom_range(0, 119) == 0);
            rv = ($urandom_range(0, 24) == 0);
            if (mode) tk = 2'($urandom_range(0, 2));
            else if ($urandom_range(0, 3) == 0) tk = 2'($urandom_range(1, 2));
            else tk = 2'd0;
            cycle(r, rv, $urandom, tk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue_ctrl.md
Name: fetch_queue_ctrl

Overview:
Front-end fetch sequencer for the dual-issue core. Owns the fetch PC and drives the instruction ROM address pair (pc, pc+4) each cycle. Pushes both returned words into a circular instruction queue and presents the two oldest entries to decode. Handles decode back-pressure, queue-full stall and branch/exception redirect flush.

Parameters:
QUEUE_DEPTH, 8, queue entries; power of two, >= 4
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
rom_pc  out  32  ROM address for first word = fetch_pc
rom_pc_4  out  32  ROM address for second word = fetch_pc + 4 (mod 2^32)
rom_inst1  in  32  word at rom_pc; combinational, same cycle
rom_inst2  in  32  word at rom_pc_4; combinational, same cycle
redirect_valid  in  1  flush queue and restart fetch
redirect_pc  in  32  new fetch PC
issue_take  in  2  entries decode consumes this cycle (0..2)
issue_valid0  out  1  head entry valid
issue_inst0  out  32  head instruction
issue_pc0  out  32  head PC
issue_valid1  out  1  head+1 entry valid
issue_inst1  out  32  head+1 instruction
issue_pc1  out  32  head+1 PC
queue_count  out  log2(QUEUE_DEPTH)+1  occupied entries

Behaviour:
- Storage: QUEUE_DEPTH x {inst[31:0], pc[31:0]}. head/tail pointers log2(QUEUE_DEPTH) bits, wrap naturally. count register is separate.
- Reset (sync, rst=1 at edge): fetch_pc=RESET_PC, head=tail=0, count=0, state=RUN. All issue_valid* = 0. rst overrides redirect, push and pop. Mid-operation reset discards all contents.
- rom_pc/rom_pc_4 are combinational from fetch_pc, including during rst.
- Issue outputs are combinational from the queue:
  - issue_valid0 = (count>=1); issue_valid1 = (count>=2).
  - inst/pc of an invalid slot are don't-care; the bench must not check them.
- Pop: pop_n = min(issue_take, count). Over-request is clamped with no underflow. head += pop_n.
- Push: fetch_en = state==RUN && !redirect_valid && (QUEUE_DEPTH - count) >= 2. The free-slot check uses count before this cycle's pop, which keeps it conservative.
  - On fetch_en, write {rom_inst1, fetch_pc} at tail and {rom_inst2, fetch_pc+4} at tail+1; tail += 2; fetch_pc += 8 (mod 2^32).
- count_next = count - pop_n + 2*fetch_en. Simultaneous push and pop in the same cycle is legal.
- State machine:
  - RUN: normal operation. If fetch_en=0 because the queue is full, go to STALL.
  - STALL: no push. Return to RUN when the free-slot check passes, with the check evaluated on count after this cycle's pop. The first push occurs the cycle after return.
  - redirect_valid=1 in any state has priority over push and pop, and over a pop in the same cycle (pops ignored). Next cycle: head=tail=0, count=0, fetch_pc={redirect_pc[31:2],2'b00}, state=RUN.
- Latency:
  - Redirect asserted at cycle T: ROM addressed with the new PC at T+1, pushed at T+1 edge, issue_valid0/1=1 at T+2.
  - After reset release: first push in the first cycle with rst=0; issue valid the following cycle.
- Fetch at PC 0xFFFF_FFF8: second word at 0xFFFF_FFFC; fetch_pc wraps to 0.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0], perf_stall_cnt[31:0] and perf_redirect_cnt[31:0], all saturating at 32'hFFFF_FFFF and cleared by rst.
  - perf_fetch_cnt increments on fetch_en.
  - perf_stall_cnt increments each cycle state==STALL.
  - perf_redirect_cnt increments on redirect_valid.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. ROM word n = 0x1000_0000+n. Hold rst 2 cycles, release, issue_take=0. Expect:
   - cycle 0 after release: rom_pc=0x0, push.
   - cycle 1: issue_valid0=1 with pc0=0x0/inst0=0x1000_0000, issue_valid1=1 with pc1=0x4/inst1=0x1000_0001, queue_count=2.
2. issue_take=0 for 6 cycles (DEPTH 8) -> queue_count saturates at 8 after 4 pushes, state STALL, rom_pc holds 0x20, head pc0 stays 0x0. Then issue_take=2 for one cycle -> one more push, pc0=0x8.
3. Steady issue_take=2 from reset -> queue_count settles at 2, issue_pc0 advances 0x0,0x8,0x10,..., no stall.
4. With queue_count=6, redirect_valid=1, redirect_pc=0x103 plus issue_take=2 -> next cycle queue_count=0, issue_valid0=0, rom_pc=0x100. Following cycle issue_pc0=0x100, issue_pc1=0x104.
5. queue_count=1, issue_take=2 -> queue_count becomes 2 (pop 1, push 2), no underflow, pc0 = oldest pushed entry.
6. rst=1 mid-stream with queue_count=8 and redirect_valid=1 -> next cycle queue_count=0, rom_pc=RESET_PC, issue_valid0=0. With FETCH_PERF_EN, all perf counters read 0.
